// File: rtl/decode_if.sv
// decode_if: fetch-side and execute-side handshake bundle for decode_stage.
// The decoder uses the slave modport; fetch/execute (or a bench) uses master.
interface decode_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int ALU_WIDTH     = 4
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_instr;
    logic [DATA_WIDTH-1:0]    in_pc;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_pc;
    logic [ADDRESS_WIDTH-1:0] out_rd;
    logic [ADDRESS_WIDTH-1:0] out_rs1;
    logic [ADDRESS_WIDTH-1:0] out_rs2;
    logic [DATA_WIDTH-1:0]    out_imm;
    logic [2:0]               out_imm_src;
    logic [ALU_WIDTH-1:0]     out_alu_ctrl;
    logic                     out_alu_src;
    logic                     out_reg_write;
    logic                     out_mem_write;
    logic                     out_mem_read;
    logic                     out_branch;
    logic                     out_jump;
    logic                     out_illegal;

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_imm_src, out_alu_ctrl, out_alu_src, out_reg_write, out_mem_write,
               out_mem_read, out_branch, out_jump, out_illegal
    );

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
               out_imm_src, out_alu_ctrl, out_alu_src, out_reg_write, out_mem_write,
               out_mem_read, out_branch, out_jump, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder with a 2-entry skid buffer and fully registered outputs.
// Define M_EXT_EN to also decode the RV32M multiply group (MUL/MULH/MULHSU/MULHU).
module decode_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int ALU_WIDTH     = 4
) (
    input  logic    clk,
    input  logic    rst,
    decode_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] ALU_SUM  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
`ifdef M_EXT_EN
    localparam logic [3:0] ALU_MUL  = 4'b1010;
`endif

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_U = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    pc;
        logic [ADDRESS_WIDTH-1:0] rd;
        logic [ADDRESS_WIDTH-1:0] rs1;
        logic [ADDRESS_WIDTH-1:0] rs2;
        logic [DATA_WIDTH-1:0]    imm;
        logic [2:0]               imm_src;
        logic [ALU_WIDTH-1:0]     alu_ctrl;
        logic                     alu_src;
        logic                     reg_write;
        logic                     mem_write;
        logic                     mem_read;
        logic                     branch;
        logic                     jump;
        logic                     illegal;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

    state_t      state_q, state_d, step_state;
    entry_t      out_q, out_d, skid_q, skid_d, dec;
    logic        out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic        accept, r_base_legal;
    logic [31:0] instr, imm32;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3, imm_src;
    logic [3:0]  alu4;
    logic        alu_src, reg_write, mem_write, mem_read, branch, jump, illegal;

    // Shared funct3 -> ALU mapping for register and immediate arithmetic; alt selects SUB/SRA.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_SUM;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_SUM;
        endcase
        return code;
    endfunction

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign accept = bus.in_valid & in_ready_q;
    assign r_base_legal = (funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    // Opcode decode into control enables; illegal encodings keep every enable low and ALU at SUM.
    always_comb begin
        alu4      = ALU_SUM;
        imm_src   = IMM_I;
        alu_src   = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                if (r_base_legal) begin
                    reg_write = 1'b1;
                    alu4      = alu_of(funct3, funct7[5]);
                end
`ifdef M_EXT_EN
                else if ((funct7 == 7'b0000001) && !funct3[2]) begin
                    reg_write = 1'b1;
                    alu4      = ALU_MUL + {2'b00, funct3[1:0]};
                end
`endif
                else begin
                    illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                reg_write = 1'b1;
                mem_read  = 1'b1;
                alu_src   = 1'b1;
            end
            OP_IMM: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu4      = alu_of(funct3, instr[30] & (funct3 == 3'b101));
            end
            OP_STORE: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_S;
            end
            OP_BRANCH: begin
                branch  = 1'b1;
                alu4    = ALU_SUB;
                imm_src = IMM_B;
            end
            OP_AUIPC, OP_LUI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_U;
            end
            OP_JALR: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                alu_src   = 1'b1;
            end
            OP_JAL: begin
                reg_write = 1'b1;
                jump      = 1'b1;
                alu_src   = 1'b1;
                imm_src   = IMM_J;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Immediate selection and packing of the decoded entry captured on accept.
    always_comb begin
        case (imm_src)
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = {{20{instr[31]}}, instr[31:20]};
        endcase
        dec           = '0;
        dec.pc        = bus.in_pc;
        dec.rd        = ADDRESS_WIDTH'(instr[11:7]);
        dec.rs1       = ADDRESS_WIDTH'(instr[19:15]);
        dec.rs2       = ADDRESS_WIDTH'(instr[24:20]);
        dec.imm       = DATA_WIDTH'($signed(imm32));
        dec.imm_src   = imm_src;
        dec.alu_ctrl  = ALU_WIDTH'(alu4);
        dec.alu_src   = alu_src;
        dec.reg_write = reg_write;
        dec.mem_write = mem_write;
        dec.mem_read  = mem_read;
        dec.branch    = branch;
        dec.jump      = jump;
        dec.illegal   = illegal;
    end

    // Skid-buffer next state: the output register only changes when it is empty or being consumed.
    always_comb begin
        step_state = state_q;
        out_d      = out_q;
        skid_d     = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    step_state = S_ONE;
                    out_d      = dec;
                end else begin
                    step_state = S_EMPTY;
                end
            end
            S_ONE: begin
                if (accept && bus.out_ready) begin
                    out_d = dec;
                end else if (accept) begin
                    skid_d     = dec;
                    step_state = S_TWO;
                end else if (bus.out_ready) begin
                    step_state = S_EMPTY;
                end else begin
                    step_state = S_ONE;
                end
            end
            S_TWO: begin
                if (bus.out_ready) begin
                    out_d      = skid_q;
                    step_state = S_ONE;
                end else begin
                    step_state = S_TWO;
                end
            end
            default: step_state = S_EMPTY;
        endcase
        state_d     = bus.flush ? S_EMPTY : step_state;
        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_TWO);
    end

    // State, entry storage and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_pc        = out_q.pc;
    assign bus.out_rd        = out_q.rd;
    assign bus.out_rs1       = out_q.rs1;
    assign bus.out_rs2       = out_q.rs2;
    assign bus.out_imm       = out_q.imm;
    assign bus.out_imm_src   = out_q.imm_src;
    assign bus.out_alu_ctrl  = out_q.alu_ctrl;
    assign bus.out_alu_src   = out_q.alu_src;
    assign bus.out_reg_write = out_q.reg_write;
    assign bus.out_mem_write = out_q.mem_write;
    assign bus.out_mem_read  = out_q.mem_read;
    assign bus.out_branch    = out_q.branch;
    assign bus.out_jump      = out_q.jump;
    assign bus.out_illegal   = out_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random stimulus against a queue-based reference of decode_stage.
// Expected decodes are computed arithmetically from the RV32I encoding rules.
module tb_decode_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int LW = 4;
`ifdef M_EXT_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [2:0]  imm_src;
        logic [3:0]  alu;
        logic        alu_src, reg_write, mem_write, mem_read, branch, jump, illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [31:0] pc_n = 32'h0000_1000;

    decode_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALU_WIDTH(LW)) bus ();
    decode_stage #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ALU_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t       e;
        int         s;
        int         imm [5];
        int         base_alu [8];
        logic [6:0] f7;
        logic [2:0] f3;
        logic [2:0] src;
        base_alu = '{0, 4, 5, 9, 6, 7, 3, 2};
        s = $signed(ins);
        imm[0] = s >>> 20;
        imm[1] = int'(ins & 32'hFFFF_F000);
        imm[2] = (s >>> 25) * 32 + int'(ins[11:7]);
        imm[3] = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        imm[4] = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        e = '0;
        e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        f7 = ins[31:25]; f3 = ins[14:12]; src = 3'd0;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin e.reg_write = 1'b1; e.alu = 4'(base_alu[f3]); end
                else if (f7 == 7'h20 && f3 == 3'd0) begin e.reg_write = 1'b1; e.alu = 4'd1; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin e.reg_write = 1'b1; e.alu = 4'd8; end
                else if (M_EN && f7 == 7'h01 && f3 < 3'd4) begin e.reg_write = 1'b1; e.alu = 4'd10 + 4'(f3); end
                else e.illegal = 1'b1;
            end
            7'h03: begin e.reg_write = 1'b1; e.mem_read = 1'b1; e.alu_src = 1'b1; end
            7'h13: begin
                e.reg_write = 1'b1; e.alu_src = 1'b1;
                e.alu = (f3 == 3'd5 && ins[30]) ? 4'd8 : 4'(base_alu[f3]);
            end
            7'h23: begin e.mem_write = 1'b1; e.alu_src = 1'b1; src = 3'd2; end
            7'h63: begin e.branch = 1'b1; e.alu = 4'd1; src = 3'd3; end
            7'h17, 7'h37: begin e.reg_write = 1'b1; e.alu_src = 1'b1; src = 3'd1; end
            7'h67: begin e.reg_write = 1'b1; e.jump = 1'b1; e.alu_src = 1'b1; end
            7'h6F: begin e.reg_write = 1'b1; e.jump = 1'b1; e.alu_src = 1'b1; src = 3'd4; end
            default: e.illegal = 1'b1;
        endcase
        e.imm_src = src;
        e.imm = 32'(imm[src]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        if (q.size() != 0) begin
            e = q[0];
            chk("pc", 64'(bus.out_pc), 64'(e.pc));
            chk("rd", 64'(bus.out_rd), 64'(e.rd));
            chk("rs1", 64'(bus.out_rs1), 64'(e.rs1));
            chk("rs2", 64'(bus.out_rs2), 64'(e.rs2));
            chk("imm", 64'(bus.out_imm), 64'(e.imm));
            chk("imm_src", 64'(bus.out_imm_src), 64'(e.imm_src));
            chk("alu_ctrl", 64'(bus.out_alu_ctrl), 64'(e.alu));
            chk("alu_src", 64'(bus.out_alu_src), 64'(e.alu_src));
            chk("reg_write", 64'(bus.out_reg_write), 64'(e.reg_write));
            chk("mem_write", 64'(bus.out_mem_write), 64'(e.mem_write));
            chk("mem_read", 64'(bus.out_mem_read), 64'(e.mem_read));
            chk("branch", 64'(bus.out_branch), 64'(e.branch));
            chk("jump", 64'(bus.out_jump), 64'(e.jump));
            chk("illegal", 64'(bus.out_illegal), 64'(e.illegal));
        end
    endtask

    // One clock of stimulus; the reference queue is a 2-deep FIFO updated at the same edge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        logic acc;
        bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc_n; bus.out_ready = ordy; bus.flush = fl;
        acc = v && (q.size() < 2) && !rst;
        @(posedge clk);
        if (rst || fl) begin
            q.delete();
        end else begin
            if (ordy && q.size() != 0) void'(q.pop_front());
            if (acc) q.push_back(model(ins, pc_n));
        end
        if (acc) pc_n = pc_n + 32'd4;
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 10))
            0, 1: ins[6:0] = 7'h33;
            2: ins[6:0] = 7'h03;
            3: ins[6:0] = 7'h13;
            4: ins[6:0] = 7'h23;
            5: ins[6:0] = 7'h63;
            6: ins[6:0] = 7'h17;
            7: ins[6:0] = 7'h37;
            8: ins[6:0] = 7'h67;
            9: ins[6:0] = 7'h6F;
            default: ins[6:0] = ins[6:0];
        endcase
        if (ins[6:0] == 7'h33) begin
            case ($urandom_range(0, 3))
                0: ins[31:25] = 7'h00;
                1: ins[31:25] = 7'h20;
                2: ins[31:25] = 7'h01;
                default: ins[31:25] = ins[31:25];
            endcase
        end
        return ins;
    endfunction

    initial begin
        bus.in_valid = 1'b0; bus.in_instr = 32'h0; bus.in_pc = 32'h0;
        bus.out_ready = 1'b0; bus.flush = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFFD0_8293, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_imm", 64'(bus.out_imm), 64'd0);
        chk("rst_ctrl", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm_src, bus.out_alu_ctrl,
                             bus.out_alu_src, bus.out_reg_write, bus.out_mem_write, bus.out_mem_read,
                             bus.out_branch, bus.out_jump, bus.out_illegal}), 64'd0);

        // addi x5,x1,-3
        cycle(1'b1, 32'hFFD0_8293, 1'b1, 1'b0);
        chk("addi_valid", 64'(bus.out_valid), 64'd1);
        chk("addi_rd", 64'(bus.out_rd), 64'd5);
        chk("addi_rs1", 64'(bus.out_rs1), 64'd1);
        chk("addi_imm", 64'(bus.out_imm), 64'hFFFF_FFFD);
        chk("addi_alu", 64'(bus.out_alu_ctrl), 64'd0);
        chk("addi_alu_src", 64'(bus.out_alu_src), 64'd1);
        chk("addi_reg_write", 64'(bus.out_reg_write), 64'd1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: three instructions against a stalled execute stage
        cycle(1'b1, 32'h0020_8133, 1'b0, 1'b0);
        cycle(1'b1, 32'h4020_81B3, 1'b0, 1'b0);
        chk("bp_in_ready_full", 64'(bus.in_ready), 64'd0);
        cycle(1'b1, 32'h0041_2203, 1'b0, 1'b0);
        chk("bp_hold_pc", 64'(bus.out_pc), 64'(pc_n - 32'd8));
        cycle(1'b1, 32'h0041_2203, 1'b1, 1'b0);
        cycle(1'b1, 32'h0041_2203, 1'b1, 1'b0);
        chk("bp_third_pc", 64'(bus.out_pc), 64'(pc_n - 32'd4));
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush from the full state, then flush while accepting from ONE
        cycle(1'b1, 32'h0010_0093, 1'b0, 1'b0);
        cycle(1'b1, 32'h0020_0113, 1'b0, 1'b0);
        cycle(1'b1, 32'h0030_0193, 1'b0, 1'b1);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        cycle(1'b1, 32'h0040_0213, 1'b0, 1'b0);
        cycle(1'b1, 32'h0050_0293, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_accept_dropped", 64'(bus.out_valid), 64'd0);

        // Branch and jump immediates
        cycle(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
        chk("beq_imm", 64'(bus.out_imm), 64'hFFFF_FFFC);
        chk("beq_branch", 64'(bus.out_branch), 64'd1);
        chk("beq_alu", 64'(bus.out_alu_ctrl), 64'd1);
        cycle(1'b1, 32'h0010_006F, 1'b1, 1'b0);
        chk("jal_imm", 64'(bus.out_imm), 64'h0000_0800);
        chk("jal_jump", 64'(bus.out_jump), 64'd1);

        // Illegal encoding and multiply
        cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0);
        chk("zero_illegal", 64'(bus.out_illegal), 64'd1);
        chk("zero_reg_write", 64'(bus.out_reg_write), 64'd0);
        cycle(1'b1, 32'h0220_81B3, 1'b1, 1'b0);
`ifdef M_EXT_EN
        chk("mul_alu", 64'(bus.out_alu_ctrl), 64'b1010);
        chk("mul_illegal", 64'(bus.out_illegal), 64'd0);
`else
        chk("mul_illegal", 64'(bus.out_illegal), 64'd1);
        chk("mul_reg_write", 64'(bus.out_reg_write), 64'd0);
`endif
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic with random back-pressure and occasional flush
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 9) < 7), rand_instr(), ($urandom_range(0, 9) < 6),
                  ($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
